// File: rtl/seq_loop_pkg.sv
// Shared types for the sequential-loop tracker: FSM encoding, counter default and
// the per-edge event bundle decoded from the state stream.
package seq_loop_pkg;

   localparam int unsigned FSM_WIDTH_DEF = 2;
   localparam int unsigned CNT_WIDTH_DEF = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      IN_LOOP = 2'd1,
      DONE    = 2'd2
   } tracker_state_t;

   typedef struct packed {
      logic entry;
      logic restart;
      logic exit;
      logic post_hit;
   } loop_event_t;

endpackage

// File: rtl/seq_loop_match.sv
// Combinational event decode: compares (prev_state, cur_state) against the loop
// descriptor and reports entry / restart / exit / post-state hits.
module seq_loop_match
   import seq_loop_pkg::*;
#(
   parameter int unsigned FSM_WIDTH = FSM_WIDTH_DEF
) (
   input  logic                 prev_valid,
   input  logic [FSM_WIDTH-1:0] prev_state,
   input  logic [FSM_WIDTH-1:0] cur_state,
   input  logic                 pre_states_valid,
   input  logic [FSM_WIDTH-1:0] pre_loop_state0,
   input  logic [2:0]           post_states_valid,
   input  logic [FSM_WIDTH-1:0] post_loop_state0,
   input  logic [FSM_WIDTH-1:0] post_loop_state1,
   input  logic [FSM_WIDTH-1:0] post_loop_state2,
   input  logic                 quit_states_valid,
   input  logic [FSM_WIDTH-1:0] quit_loop_state0,
   input  logic [FSM_WIDTH-1:0] loop_quit_state,
   input  logic [FSM_WIDTH-1:0] iter_start_state,
   input  logic                 iter_end_states_valid,
   input  logic [FSM_WIDTH-1:0] iter_end_state0,
   input  logic                 one_state_loop,
   input  logic                 one_state_block,
   output loop_event_t          evt_c
);

   logic at_start;
   logic prev_at_start;
   logic end_match;
   logic pre_ok;
   logic quit_ok;
   logic post_any;

   always_comb begin
      at_start      = (cur_state == iter_start_state);
      prev_at_start = (prev_state == iter_start_state);
      end_match     = one_state_block ? prev_at_start
                                      : (iter_end_states_valid && (prev_state == iter_end_state0));
      pre_ok        = !pre_states_valid || (prev_state == pre_loop_state0);
      quit_ok       = quit_states_valid ? (prev_state == quit_loop_state0)
                                        : (prev_state != loop_quit_state);
      post_any      = (post_states_valid[0] && (cur_state == post_loop_state0))
                   || (post_states_valid[1] && (cur_state == post_loop_state1))
                   || (post_states_valid[2] && (cur_state == post_loop_state2));

      // Nothing is meaningful until prev_state holds a real sample.
      evt_c          = '0;
      evt_c.entry    = prev_valid && at_start && !prev_at_start && pre_ok;
      evt_c.restart  = prev_valid && at_start && (one_state_loop ? prev_at_start : end_match);
      evt_c.exit     = prev_valid && (cur_state == loop_quit_state) && quit_ok;
      evt_c.post_hit = prev_valid && post_any;
   end

endmodule

// File: rtl/seq_loop_tracker.sv
// Passive loop tracker: follows the DUT FSM state stream, reconstructs loop trips and
// iterations, counts them and raises sticky protocol-violation flags.
module seq_loop_tracker
   import seq_loop_pkg::*;
#(
   parameter int unsigned FSM_WIDTH = FSM_WIDTH_DEF,
   parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [FSM_WIDTH-1:0] cur_state,
   input  logic                 pre_states_valid,
   input  logic [FSM_WIDTH-1:0] pre_loop_state0,
   input  logic [2:0]           post_states_valid,
   input  logic [FSM_WIDTH-1:0] post_loop_state0,
   input  logic [FSM_WIDTH-1:0] post_loop_state1,
   input  logic [FSM_WIDTH-1:0] post_loop_state2,
   input  logic                 quit_states_valid,
   input  logic [FSM_WIDTH-1:0] quit_loop_state0,
   input  logic [FSM_WIDTH-1:0] loop_quit_state,
   input  logic [FSM_WIDTH-1:0] iter_start_state,
   input  logic                 iter_end_states_valid,
   input  logic [FSM_WIDTH-1:0] iter_end_state0,
   input  logic                 one_state_loop,
   input  logic                 one_state_block,
   input  logic                 finish,
   output logic                 loop_active,
   output logic                 iter_start_pulse,
   output logic                 iter_done_pulse,
   output logic                 loop_exit_pulse,
   output logic [CNT_WIDTH-1:0] iter_count,
   output logic [CNT_WIDTH-1:0] trip_count,
   output logic                 trip_valid,
   output logic                 err_illegal_exit,
   output logic                 err_unterminated,
   output logic                 err_overflow
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   tracker_state_t         state;
   tracker_state_t         state_next;
   logic [FSM_WIDTH-1:0]   prev_state;
   logic                   prev_valid;
   loop_event_t            evt;

   logic                   loop_active_d;
   logic                   iter_start_d;
   logic                   iter_done_d;
   logic                   loop_exit_d;
   logic [CNT_WIDTH-1:0]   iter_count_d;
   logic [CNT_WIDTH-1:0]   trip_count_d;
   logic                   trip_valid_d;
   logic                   err_illegal_exit_d;
   logic                   err_unterminated_d;
   logic                   err_overflow_d;

   seq_loop_match #(
      .FSM_WIDTH (FSM_WIDTH)
   ) u_match (
      .prev_valid            (prev_valid),
      .prev_state            (prev_state),
      .cur_state             (cur_state),
      .pre_states_valid      (pre_states_valid),
      .pre_loop_state0       (pre_loop_state0),
      .post_states_valid     (post_states_valid),
      .post_loop_state0      (post_loop_state0),
      .post_loop_state1      (post_loop_state1),
      .post_loop_state2      (post_loop_state2),
      .quit_states_valid     (quit_states_valid),
      .quit_loop_state0      (quit_loop_state0),
      .loop_quit_state       (loop_quit_state),
      .iter_start_state      (iter_start_state),
      .iter_end_states_valid (iter_end_states_valid),
      .iter_end_state0       (iter_end_state0),
      .one_state_loop        (one_state_loop),
      .one_state_block       (one_state_block),
      .evt_c                 (evt)
   );

   // FSM state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state: finish wins everywhere; inside the loop exit > restart > post_hit
   always_comb begin
      state_next = state;
      if (finish) begin
         state_next = DONE;
      end else begin
         unique case (state)
            IDLE: begin
               if (evt.entry) state_next = IN_LOOP;
            end
            IN_LOOP: begin
               if (evt.exit)          state_next = IDLE;
               else if (evt.restart)  state_next = IN_LOOP;
               else if (evt.post_hit) state_next = IDLE;
            end
            DONE:    state_next = DONE;
            default: state_next = IDLE;
         endcase
      end
   end

   // Output / counter next values
   always_comb begin
      iter_start_d       = 1'b0;
      iter_done_d        = 1'b0;
      loop_exit_d        = 1'b0;
      iter_count_d       = iter_count;
      trip_count_d       = trip_count;
      trip_valid_d       = trip_valid;
      err_illegal_exit_d = err_illegal_exit;
      err_unterminated_d = err_unterminated;
      err_overflow_d     = err_overflow;

      if (finish) begin
         if (state == IN_LOOP) err_unterminated_d = 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (evt.entry) begin
                  iter_count_d = CNT_WIDTH'(1);
                  iter_start_d = 1'b1;
                  trip_valid_d = 1'b0;
               end
            end
            IN_LOOP: begin
               if (evt.exit) begin
                  iter_done_d  = 1'b1;
                  loop_exit_d  = 1'b1;
                  trip_count_d = iter_count;
                  trip_valid_d = 1'b1;
               end else if (evt.restart) begin
                  iter_done_d  = 1'b1;
                  iter_start_d = 1'b1;
                  // Saturate rather than wrap; the lost increment is flagged.
                  if (iter_count == CNT_MAX) begin
                     err_overflow_d = 1'b1;
                  end else begin
                     iter_count_d = iter_count + CNT_WIDTH'(1);
                  end
               end else if (evt.post_hit) begin
                  err_illegal_exit_d = 1'b1;
               end
            end
            default: ;
         endcase
      end

      loop_active_d = (state_next == IN_LOOP);
   end

   // Registered outputs and previous-state sample
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev_state       <= '0;
         prev_valid       <= 1'b0;
         loop_active      <= 1'b0;
         iter_start_pulse <= 1'b0;
         iter_done_pulse  <= 1'b0;
         loop_exit_pulse  <= 1'b0;
         iter_count       <= '0;
         trip_count       <= '0;
         trip_valid       <= 1'b0;
         err_illegal_exit <= 1'b0;
         err_unterminated <= 1'b0;
         err_overflow     <= 1'b0;
      end else begin
         prev_state       <= cur_state;
         prev_valid       <= 1'b1;
         loop_active      <= loop_active_d;
         iter_start_pulse <= iter_start_d;
         iter_done_pulse  <= iter_done_d;
         loop_exit_pulse  <= loop_exit_d;
         iter_count       <= iter_count_d;
         trip_count       <= trip_count_d;
         trip_valid       <= trip_valid_d;
         err_illegal_exit <= err_illegal_exit_d;
         err_unterminated <= err_unterminated_d;
         err_overflow     <= err_overflow_d;
      end
   end

endmodule
